pkt_deser: RTL
==============

Name: pkt_deser

Overview:
- Receive-side counterpart of the packet shift-out register.
- Collects a serial bit stream, MSB first, qualified by a per-bit flag, into a PKT_W-bit packet.
- Each completed packet is handed to a downstream consumer through a registered valid/ack handshake.
- The output register is separate from the shift register, so the next packet can shift in while the previous one waits for ack.

Parameters:
- PKT_W, 64: packet width in bits (must be ≥2).
- CNT_W, 7: bit-counter width; must satisfy 2^CNT_W > PKT_W.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- sin  in  1  serial data bit.
- pkt_flg  in  1  sin is a valid packet bit this cycle.
- pkt_clr  in  1  synchronous abort of the partially received packet.
- pkt_ack  in  1  consumer accepts dout this cycle (meaningful only while pkt_vld=1).
- dout  out  PKT_W  last completed packet; first received bit is at dout[PKT_W-1].
- pkt_vld  out  1  dout holds an unconsumed packet.
- ovf  out  1  sticky flag: a completed packet was dropped.
- bit_cnt  out  CNT_W  number of bits collected in the current partial packet.

Behaviour:
- Reset (rst=1 at an edge): sreg=0, bit_cnt=0, dout=0, pkt_vld=0, ovf=0, FSM=IDLE. Reset overrides every other input.
- FSM states:
  - IDLE: bit_cnt=0.
  - SHIFT: 0 < bit_cnt < PKT_W.
- IDLE→SHIFT on the first pkt_flg=1 cycle.
- SHIFT→IDLE when the PKT_W-th bit is taken, or when pkt_clr=1.
- Shift rule: on an edge with pkt_flg=1 and pkt_clr=0, sreg <= {sreg[PKT_W-2:0], sin} and bit_cnt increments.
- pkt_flg=0 pauses reception: no shift, bit_cnt holds. There is no timeout.
- pkt_clr=1: bit_cnt<=0, sreg<=0, FSM=IDLE. The sin bit on that edge is discarded even if pkt_flg=1. pkt_clr does not affect dout, pkt_vld or ovf.
- Completion: on the edge where pkt_flg=1 and bit_cnt==PKT_W-1, the full packet is {sreg[PKT_W-2:0], sin}. On that same edge:
  - bit_cnt wraps to 0 and the FSM returns to IDLE.
  - A pkt_flg=1 on the next cycle starts the next packet, so back-to-back packets need no gap.
- Load rule on completion:
  - If pkt_vld=0, or pkt_vld=1 with pkt_ack=1 on that edge: dout <= full packet, pkt_vld <= 1.
  - Otherwise the new packet is dropped: dout and pkt_vld unchanged, ovf <= 1.
- Latency: dout and pkt_vld are valid immediately after the edge that samples the final bit, i.e. zero extra cycles.
- Handshake:
  - pkt_vld stays high and dout stays stable until an edge with pkt_ack=1.
  - On that edge pkt_vld <= 0 unless a completion loads a new packet on the same edge, in which case pkt_vld stays 1 and dout updates.
  - pkt_ack while pkt_vld=0 is ignored.
  - dout is not cleared on ack; it keeps the last packet.
- ovf is cleared only by rst.
- bit_cnt never reaches PKT_W.

Test Plan:
- rst 1 cycle, then 64 consecutive pkt_flg=1 cycles driving the bits of 64'hAAAAAAAAAAAAAAAA MSB first -> pkt_vld=1 after edge 64, dout=64'hAAAAAAAAAAAAAAAA, bit_cnt=0, ovf=0. pkt_ack 1 cycle -> pkt_vld=0, dout unchanged.
- Stream 64'h0123456789ABCDEF with pkt_flg low for 3 cycles after bits 10 and 40 -> bit_cnt holds during gaps, dout=64'h0123456789ABCDEF, pkt_vld asserts on the 64th valid bit.
- Back-to-back packets 64'hFFFF0000FFFF0000 then 64'h1, ack asserted on the same edge as the second completion -> pkt_vld stays 1 across that edge, dout=64'h1, ovf=0.
- Two packets with no ack -> dout retains the first packet, ovf=1 after the second completion, and ovf stays 1 after a later ack.
- pkt_clr after 20 bits, then a full packet 64'hDEADBEEFCAFEF00D -> bit_cnt=0 after the clear, dout=64'hDEADBEEFCAFEF00D, no residue from the aborted bits.
- rst mid-packet (bit_cnt=33) with pkt_vld=1 and ovf=1 -> all outputs 0 on the next edge, then a fresh packet is received correctly.

Source files
------------

// File: rtl/pkt_deser.sv
// pkt_deser: serial-to-parallel packet receiver.
// Shifts in a qualified serial stream (MSB first) into a PKT_W-bit packet and
// hands each completed packet to a consumer over a registered valid/ack pair.
// A separate output register lets the next packet shift in while the previous
// one waits for ack.
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   sin      serial data bit
//   pkt_flg  sin carries a valid packet bit this cycle
//   pkt_clr  abort the partially received packet
//   pkt_ack  consumer accepts dout (only meaningful while pkt_vld=1)
//   dout     last completed packet, first received bit at dout[PKT_W-1]
//   pkt_vld  dout holds an unconsumed packet
//   ovf      sticky: a completed packet was dropped
//   bit_cnt  bits collected in the current partial packet
module pkt_deser #(
  parameter int unsigned PKT_W = 64,
  parameter int unsigned CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             pkt_flg,
  input  logic             pkt_clr,
  input  logic             pkt_ack,
  output logic [PKT_W-1:0] dout,
  output logic             pkt_vld,
  output logic             ovf,
  output logic [CNT_W-1:0] bit_cnt
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PKT_W - 1);

  logic [0:0]       state;
  logic [0:0]       state_nxt;
  logic [PKT_W-1:0] sreg;
  logic [PKT_W-1:0] sreg_nxt;
  logic [PKT_W-1:0] full_c;
  logic [PKT_W-1:0] dout_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             vld_nxt;
  logic             ovf_nxt;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      sreg    <= '0;
      bit_cnt <= '0;
      dout    <= '0;
      pkt_vld <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      state   <= state_nxt;
      sreg    <= sreg_nxt;
      bit_cnt <= cnt_nxt;
      dout    <= dout_nxt;
      pkt_vld <= vld_nxt;
      ovf     <= ovf_nxt;
    end
  end

  // Next-state, shift and handshake logic
  always_comb begin
    state_nxt = state;
    sreg_nxt  = sreg;
    cnt_nxt   = bit_cnt;
    dout_nxt  = dout;
    vld_nxt   = pkt_vld;
    ovf_nxt   = ovf;
    full_c    = {sreg[PKT_W-2:0], sin};

    // Ack retires the held packet; a same-edge completion may reload it below.
    if (pkt_vld && pkt_ack) begin
      vld_nxt = 1'b0;
    end

    if (pkt_clr) begin
      state_nxt = IDLE;
      sreg_nxt  = '0;
      cnt_nxt   = '0;
    end else if (pkt_flg) begin
      sreg_nxt = full_c;
      case (state)
        IDLE: begin
          state_nxt = SHIFT;
          cnt_nxt   = CNT_W'(1);
        end
        default: begin
          if (bit_cnt == LAST_CNT) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            // Output register is free if empty or being acked this edge.
            if (!pkt_vld || pkt_ack) begin
              dout_nxt = full_c;
              vld_nxt  = 1'b1;
            end else begin
              ovf_nxt = 1'b1;
            end
          end else begin
            cnt_nxt = bit_cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

endmodule
